// File: rtl/seg_frame_scheduler_if.sv
// Producer-side frame offers and the held-frame outputs toward the display scanner.
interface seg_frame_scheduler_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                clear;
  logic [31:0]         frame_out;
  logic                frame_valid;
  logic                frame_load;
  logic [N_REQ-1:0]    owner;

  modport master (
    output req_valid, req_data, clear,
    input  req_ready, frame_out, frame_valid, frame_load, owner
  );

  modport slave (
    input  req_valid, req_data, clear,
    output req_ready, frame_out, frame_valid, frame_load, owner
  );
endinterface

// File: rtl/seg_frame_scheduler.sv
// Purpose: round-robin share of the 8-digit display among N_REQ frame producers.
// Latency: request in IDLE -> ready next cycle -> frame visible the cycle after.
// Backpressure: one one-hot ready pulse per frame, at most every HOLD_CYC+1 cycles.
module seg_frame_scheduler #(
  parameter int N_REQ    = 3,
  parameter int HOLD_CYC = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_frame_scheduler_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(HOLD_CYC + 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    grant_idx;
  logic [N_REQ-1:0] grant_oh;
  logic [CW-1:0]    hold_cnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic [31:0]      frame_sel;
  logic [IW-1:0]    next_ptr;

  // Scan from the farthest offset down so the requester nearest ptr wins.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if ((j == (int'(ptr) + k) % N_REQ) && bus.req_valid[j]) begin
          pick_idx = IW'(j);
          pick_any = 1'b1;
        end
      end
    end
  end

  always_comb begin
    frame_sel = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == IW'(k)) frame_sel = bus.req_data[32*k +: 32];
    end
  end

  assign next_ptr = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // grant_oh is only non-zero in GRANT; clear or reset withdraws the offer so no transfer happens.
  assign bus.req_ready = grant_oh & {N_REQ{~bus.clear & ~rst}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      grant_idx       <= '0;
      grant_oh        <= '0;
      hold_cnt        <= '0;
      bus.frame_out   <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_load  <= 1'b0;
      bus.owner       <= '0;
    end else if (bus.clear) begin
      state           <= IDLE;
      grant_oh        <= '0;
      hold_cnt        <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_load  <= 1'b0;
      bus.owner       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_idx <= pick_idx;
            grant_oh  <= N_REQ'(1) << pick_idx;
            state     <= GRANT;
          end
        end
        GRANT: begin
          bus.frame_out   <= frame_sel;
          bus.owner       <= grant_oh;
          bus.frame_load  <= 1'b1;
          bus.frame_valid <= 1'b1;
          hold_cnt        <= '0;
          ptr             <= next_ptr;
          grant_oh        <= '0;
          state           <= SHOW;
        end
        SHOW: begin
          bus.frame_load <= 1'b0;
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else if (pick_any) begin
            grant_idx <= pick_idx;
            grant_oh  <= N_REQ'(1) << pick_idx;
            state     <= GRANT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seg_frame_scheduler.sv
// Bench for seg_frame_scheduler: directed scenarios plus randomized traffic against a frame-lifetime model.
module tb_seg_frame_scheduler;
  localparam int N = 3;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst;
  seg_frame_scheduler_if #(.N_REQ(N)) bus ();

  seg_frame_scheduler #(.N_REQ(N), .HOLD_CYC(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // producers
  logic [N-1:0] p_valid;
  logic [31:0]  p_data [N];
  logic         reoffer;
  logic         clear_i;

  // observations of the most recently stepped cycle
  logic [N-1:0] obs_ready;
  logic [31:0]  obs_frame;
  logic         obs_valid;
  logic         obs_load;
  logic [N-1:0] obs_owner;

  // model: a frame is either being granted, shown for some number of cycles, or absent
  bit          m_known;
  int          m_ptr;
  int          m_gnt;
  int          m_shown;
  logic        m_valid;
  logic        m_load;
  logic [31:0] m_frame;
  logic [N-1:0] m_owner;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req_valid = p_valid;
    bus.req_data  = {p_data[2], p_data[1], p_data[0]};
    bus.clear     = clear_i;
  endtask

  function automatic int rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_known = 1'b1; m_ptr = 0; m_gnt = -1; m_shown = 0;
      m_valid = 1'b0; m_load = 1'b0; m_frame = '0; m_owner = '0;
    end else if (!m_known) begin
      m_known = 1'b0;
    end else if (clear_i) begin
      m_gnt = -1; m_valid = 1'b0; m_owner = '0; m_load = 1'b0; m_shown = 0;
    end else if (m_gnt >= 0) begin
      m_frame = p_data[m_gnt];
      m_owner = N'(1) << m_gnt;
      m_valid = 1'b1;
      m_load  = 1'b1;
      m_shown = 1;
      m_ptr   = (m_gnt + 1) % N;
      m_gnt   = -1;
    end else begin
      m_load = 1'b0;
      if ((!m_valid || m_shown >= H) && (|p_valid)) m_gnt = rr_pick(p_valid, m_ptr);
      else if (m_valid) m_shown++;
    end
  endtask

  task automatic step();
    logic [N-1:0] xfer;
    logic [N-1:0] m_ready;
    drive();
    #1;
    obs_ready = bus.req_ready;
    obs_frame = bus.frame_out;
    obs_valid = bus.frame_valid;
    obs_load  = bus.frame_load;
    obs_owner = bus.owner;
    if (m_known) begin
      m_ready = (m_gnt >= 0 && !clear_i && !rst) ? (N'(1) << m_gnt) : '0;
      chk("req_ready",   32'(obs_ready), 32'(m_ready));
      chk("frame_out",   obs_frame,      m_frame);
      chk("frame_valid", 32'(obs_valid), 32'(m_valid));
      chk("frame_load",  32'(obs_load),  32'(m_load));
      chk("owner",       32'(obs_owner), 32'(m_owner));
    end
    xfer = rst ? '0 : (bus.req_valid & bus.req_ready);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (xfer[i]) begin
        if (reoffer) p_data[i] = $urandom;
        else         p_valid[i] = 1'b0;
      end
    end
    drive();
  endtask

  initial begin
    int grants[$];
    int loads[$];
    int bad;
    int exp_order[5] = '{0, 1, 2, 0, 1};

    m_known = 1'b0; m_gnt = -1; m_ptr = 0; m_shown = 0;
    m_valid = 1'b0; m_load = 1'b0; m_frame = '0; m_owner = '0;
    rst = 1'b1; clear_i = 1'b0; reoffer = 1'b0;
    p_valid = N'($urandom);
    for (int i = 0; i < N; i++) p_data[i] = $urandom;
    drive();
    @(negedge clk);

    // reset with random requests
    step();
    p_valid = N'($urandom);
    step();
    chk("rst_ready", 32'(obs_ready), 32'(0));
    chk("rst_valid", 32'(obs_valid), 32'(0));
    chk("rst_frame", obs_frame, 32'h0);

    // single request latency
    rst = 1'b0;
    p_valid = 3'b001; p_data[0] = 32'h20040404; p_data[1] = '0; p_data[2] = '0;
    step();
    chk("lat_ready_t0", 32'(obs_ready), 32'(0));
    step();
    chk("lat_ready_t1", 32'(obs_ready), 32'(3'b001));
    step();
    chk("lat_frame_t2", obs_frame, 32'h20040404);
    chk("lat_load_t2",  32'(obs_load),  32'(1));
    chk("lat_valid_t2", 32'(obs_valid), 32'(1));
    chk("lat_owner_t2", 32'(obs_owner), 32'(3'b001));

    // long idle: frame retained, no load pulses
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (obs_load !== 1'b0 || obs_frame !== 32'h20040404 || obs_valid !== 1'b1) bad++;
    end
    chk("idle_stable", 32'(bad), 32'(0));

    // saturated hold: a late request is granted at once
    p_valid = 3'b010; p_data[1] = 32'h11111111;
    step();
    step();
    chk("late_ready", 32'(obs_ready), 32'(3'b010));

    // request arriving in the first SHOW cycle waits for the hold
    p_valid = 3'b100; p_data[2] = 32'h22222222;
    step();
    chk("hold_load", 32'(obs_load), 32'(1));
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold_no_ready", 32'(obs_ready), 32'(0));
      chk("hold_frame", obs_frame, 32'h11111111);
    end
    step();
    chk("hold_ready", 32'(obs_ready), 32'(3'b100));
    step();
    chk("hold_new_frame", obs_frame, 32'h22222222);
    chk("hold_new_owner", 32'(obs_owner), 32'(3'b100));

    // all busy: round-robin order and frame period
    p_valid = 3'b111; reoffer = 1'b1;
    for (int i = 0; i < N; i++) p_data[i] = $urandom;
    for (int c = 0; c < 26; c++) begin
      step();
      for (int i = 0; i < N; i++) if (obs_ready[i]) grants.push_back(i);
      if (obs_load) loads.push_back(c);
    end
    chk("rr_count", 32'(grants.size()), 32'(5));
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(grants[k]), 32'(exp_order[k]));
    for (int k = 0; k < 4; k++) chk("rr_period", 32'(loads[k+1] - loads[k]), 32'(H + 1));

    // clear during the GRANT cycle of requester 2
    begin
      int w = 0;
      while (m_gnt != 2 && w < 20) begin step(); w++; end
      chk("clr_wait", 32'(m_gnt), 32'(2));
    end
    clear_i = 1'b1;
    step();
    chk("clr_ready", 32'(obs_ready), 32'(0));
    clear_i = 1'b0;
    step();
    chk("clr_valid", 32'(obs_valid), 32'(0));
    chk("clr_owner", 32'(obs_owner), 32'(0));
    step();
    chk("clr_regrant", 32'(obs_ready), 32'(3'b100));
    step();
    chk("clr_reowner", 32'(obs_owner), 32'(3'b100));

    // randomized traffic with occasional clear and reset
    for (int c = 0; c < 2000; c++) begin
      rst     = ($urandom_range(0, 199) == 0);
      clear_i = ($urandom_range(0, 39) == 0);
      reoffer = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && $urandom_range(0, 3) == 0) begin
          p_valid[i] = 1'b1;
          p_data[i]  = $urandom;
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
